// File: rtl/dino_pkg.sv
// Shared definitions for the dinosaur game: obstacle types, spawner defaults
// and the spawner state encoding.
package dino_pkg;

    localparam logic [1:0] OBS_CACTUS_S = 2'd0;
    localparam logic [1:0] OBS_CACTUS_L = 2'd1;
    localparam logic [1:0] OBS_BIRD     = 2'd2;

    localparam int DEF_MIN_GAP = 24;
    localparam int DEF_SPAWN_X = 640;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } spawn_state_e;

    // Two random codes map to the small cactus so it shows up twice as often.
    function automatic logic [1:0] map_type(input logic [1:0] r);
        logic [1:0] t;
        case (r)
            2'd0:    t = OBS_CACTUS_S;
            2'd1:    t = OBS_CACTUS_L;
            2'd2:    t = OBS_BIRD;
            default: t = OBS_CACTUS_S;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/obstacle_slot.sv
// One obstacle slot: occupied flag, x position and type. Scrolls left by
// speed on each advance and retires itself once it would pass x=0.
module obstacle_slot
    import dino_pkg::*;
#(
    parameter int X_W     = 10,
    parameter int SPAWN_X = DEF_SPAWN_X
) (
    input  logic           clk,
    input  logic           RESET,
    input  logic           load,
    input  logic [1:0]     type_in,
    input  logic           advance,
    input  logic [2:0]     speed,
    output logic           valid,
    output logic [X_W-1:0] x,
    output logic [1:0]     obj_type
);

    logic [X_W-1:0] speed_ext;

    assign speed_ext = {{(X_W-3){1'b0}}, speed};

    always_ff @(posedge clk) begin
        if (RESET) begin
            valid    <= 1'b0;
            x        <= '0;
            obj_type <= 2'd0;
        end else if (advance) begin
            // A freshly loaded obstacle does not move on its spawn tick.
            if (load) begin
                valid    <= 1'b1;
                x        <= X_W'(SPAWN_X);
                obj_type <= type_in;
            end else if (valid) begin
                if (x < speed_ext) begin
                    valid <= 1'b0;
                end else begin
                    x <= x - speed_ext;
                end
            end
        end
    end

endmodule

// File: rtl/obstacle_spawner.sv
// Obstacle scheduler: gap counter, free-slot select and type map, driving
// SLOTS scrolling obstacle slots once per processed frame tick.
//
//   state   | meaning
//   IDLE    | after reset, waiting for the game to start
//   RUN     | ticks scroll obstacles and count down the spawn gap
//   HALT    | game paused, slots and gap frozen
module obstacle_spawner
    import dino_pkg::*;
#(
    parameter int SLOTS   = 3,
    parameter int X_W     = 10,
    parameter int SPAWN_X = DEF_SPAWN_X,
    parameter int MIN_GAP = DEF_MIN_GAP
) (
    input  logic               clk,
    input  logic               RESET,
    input  logic               tick,
    input  logic               run,
    input  logic [2:0]         speed,
    input  logic [4:0]         rnd,
    output logic [SLOTS-1:0]   obj_valid,
    output logic [SLOTS*X_W-1:0] obj_x,
    output logic [2*SLOTS-1:0] obj_type,
    output logic               spawn,
    output logic               dropped
);

    spawn_state_e state_q, state_d;
    logic [7:0]       gap_q;
    logic             processed;
    logic             attempt;
    logic             free_found;
    logic [SLOTS-1:0] load_vec;
    logic [1:0]       type_sel;

    always_ff @(posedge clk) begin
        if (RESET) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (run)  state_d = ST_RUN;
            ST_RUN:  if (!run) state_d = ST_HALT;
            ST_HALT: if (run)  state_d = ST_RUN;
            default:           state_d = ST_IDLE;
        endcase
    end

    // Ticks are honoured only in RUN as seen before any transition this cycle.
    assign processed = (state_q == ST_RUN) && tick;
    assign attempt   = processed && (gap_q == 8'd0);
    assign type_sel  = map_type(rnd[1:0]);

    // Free slots are judged on current flags, so a slot retiring this tick
    // cannot be refilled until the following one.
    always_comb begin
        load_vec   = '0;
        free_found = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!obj_valid[i] && !free_found) begin
                load_vec[i] = attempt;
                free_found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            gap_q   <= 8'(MIN_GAP);
            spawn   <= 1'b0;
            dropped <= 1'b0;
        end else begin
            spawn   <= attempt && free_found;
            dropped <= attempt && !free_found;
            if (processed) begin
                if (gap_q != 8'd0) gap_q <= gap_q - 8'd1;
                else               gap_q <= 8'(MIN_GAP) + {3'b000, rnd[4:2], 2'b00};
            end
        end
    end

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        obstacle_slot #(
            .X_W     (X_W),
            .SPAWN_X (SPAWN_X)
        ) u_slot (
            .clk      (clk),
            .RESET    (RESET),
            .load     (load_vec[i]),
            .type_in  (type_sel),
            .advance  (processed),
            .speed    (speed),
            .valid    (obj_valid[i]),
            .x        (obj_x[i*X_W +: X_W]),
            .obj_type (obj_type[2*i +: 2])
        );
    end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Self-checking bench for obstacle_spawner: cycle-level reference model feeding
// a scoreboard, plus hand-computed checks for the multi-cycle corner cases.
module tb_obstacle_spawner;

    localparam int SLOTS = 3;
    localparam int X_W   = 10;

    logic clk = 1'b0;
    logic RESET = 1'b1;
    logic tick = 1'b0;
    logic run = 1'b0;
    logic [2:0] speed = 3'd0;
    logic [4:0] rnd = 5'd0;
    logic [SLOTS-1:0]     obj_valid;
    logic [SLOTS*X_W-1:0] obj_x;
    logic [2*SLOTS-1:0]   obj_type;
    logic spawn, dropped;

    obstacle_spawner #(.SLOTS(3), .X_W(10), .SPAWN_X(640), .MIN_GAP(24)) dut (
        .clk(clk), .RESET(RESET), .tick(tick), .run(run), .speed(speed), .rnd(rnd),
        .obj_valid(obj_valid), .obj_x(obj_x), .obj_type(obj_type),
        .spawn(spawn), .dropped(dropped)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SLOTS-1:0]     v;
        logic [SLOTS*X_W-1:0] x;
        logic [2*SLOTS-1:0]   t;
        logic                 sp;
        logic                 dr;
    } exp_t;

    typedef struct {
        logic [4:0] rnd;
        logic [1:0] exp_type;
    } tmap_vec_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    // reference model (0 idle, 1 run, 2 halt)
    int m_state = 0;
    int m_gap = 24;
    bit m_v[SLOTS];
    int m_x[SLOTS];
    int m_t[SLOTS];
    bit m_sp, m_dr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_out();
        exp_t e;
        exp_t a;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_empty at %0t", $time);
            return;
        end
        e = sb.pop_front();
        a = {obj_valid, obj_x, obj_type, spawn, dropped};
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL cycle_model at %0t: got v=%b x=%h t=%h sp=%b dr=%b expected v=%b x=%h t=%h sp=%b dr=%b",
                     $time, a.v, a.x, a.t, a.sp, a.dr, e.v, e.x, e.t, e.sp, e.dr);
        end
    endtask

    task automatic step(input logic r, input logic tk, input logic rn,
                        input logic [2:0] sp, input logic [4:0] rd);
        exp_t e;
        int fr;
        @(negedge clk);
        RESET = r; tick = tk; run = rn; speed = sp; rnd = rd;
        if (r) begin
            m_state = 0; m_gap = 24; m_sp = 0; m_dr = 0;
            for (int i = 0; i < SLOTS; i++) begin m_v[i] = 0; m_x[i] = 0; m_t[i] = 0; end
        end else begin
            m_sp = 0; m_dr = 0;
            if (m_state == 1 && tk) begin
                fr = -1;
                for (int i = 0; i < SLOTS; i++) if (!m_v[i] && fr < 0) fr = i;
                for (int i = 0; i < SLOTS; i++) begin
                    if (m_v[i]) begin
                        if (m_x[i] < int'(sp)) m_v[i] = 0;
                        else m_x[i] = m_x[i] - int'(sp);
                    end
                end
                if (m_gap != 0) m_gap = m_gap - 1;
                else begin
                    if (fr >= 0) begin
                        m_v[fr] = 1; m_x[fr] = 640;
                        m_t[fr] = (rd[1:0] == 2'd3) ? 0 : int'(rd[1:0]);
                        m_sp = 1;
                    end else m_dr = 1;
                    m_gap = 24 + 4 * int'(rd[4:2]);
                end
            end
            case (m_state)
                0: if (rn) m_state = 1;
                1: if (!rn) m_state = 2;
                default: if (rn) m_state = 1;
            endcase
        end
        for (int i = 0; i < SLOTS; i++) begin
            e.v[i] = m_v[i];
            e.x[i*X_W +: X_W] = X_W'(m_x[i]);
            e.t[2*i +: 2] = 2'(m_t[i]);
        end
        e.sp = m_sp; e.dr = m_dr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    // tick cycle followed by a quiet cycle; caller checks between them
    task automatic tick_on(input logic [2:0] sp, input logic [4:0] rd);
        step(1'b0, 1'b1, 1'b1, sp, rd);
    endtask

    task automatic quiet(input logic [2:0] sp, input logic [4:0] rd);
        step(1'b0, 1'b0, 1'b1, sp, rd);
    endtask

    tmap_vec_t tmap[4];

    initial begin
        logic [X_W-1:0] x0, x1, x2;

        tmap[0] = '{rnd: 5'b00000, exp_type: 2'd0};
        tmap[1] = '{rnd: 5'b00001, exp_type: 2'd1};
        tmap[2] = '{rnd: 5'b00010, exp_type: 2'd2};
        tmap[3] = '{rnd: 5'b00011, exp_type: 2'd0};

        // reset, then ticks while not running
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0, 2, 5'b00101);
            chk("idle_valid", 32'(obj_valid), 0);
            chk("idle_spawn", 32'(spawn | dropped), 0);
            step(0, 0, 0, 2, 5'b00101);
        end

        // IDLE->RUN with a coincident tick that must be ignored
        step(0, 1, 1, 2, 5'b00101);
        chk("enter_run_no_move", 32'(obj_valid), 0);
        for (int k = 1; k <= 25; k++) begin
            tick_on(2, 5'b00101);
            if (k < 25) chk("first_spawn_early", 32'(spawn), 0);
            else begin
                chk("first_spawn", 32'(spawn), 1);
                chk("first_valid", 32'(obj_valid), 32'b001);
                chk("first_x", 32'(obj_x[0 +: X_W]), 640);
                chk("first_type", 32'(obj_type[1:0]), 1);
            end
            quiet(2, 5'b00101);
        end
        for (int k = 1; k <= 29; k++) begin
            tick_on(2, 5'b00101);
            if (k < 29) chk("second_spawn_early", 32'(spawn), 0);
            else begin
                chk("second_spawn", 32'(spawn), 1);
                chk("second_valid", 32'(obj_valid), 32'b011);
                chk("second_x", 32'(obj_x[X_W +: X_W]), 640);
            end
            quiet(2, 5'b00101);
        end

        // fill the third slot, then a due spawn with no free slot
        for (int k = 1; k <= 29; k++) begin
            tick_on(1, 5'b00000);
            if (k == 29) chk("third_valid", 32'(obj_valid), 32'b111);
            quiet(1, 5'b00000);
        end
        for (int k = 1; k <= 24; k++) begin
            tick_on(1, 5'b00000);
            quiet(1, 5'b00000);
        end
        x0 = obj_x[0 +: X_W];
        tick_on(1, 5'b11111);
        chk("full_dropped", 32'(dropped), 1);
        chk("full_spawn", 32'(spawn), 0);
        chk("full_valid", 32'(obj_valid), 32'b111);
        chk("full_moved", 32'(obj_x[0 +: X_W]), 32'(x0) - 1);
        quiet(1, 5'b00000);
        chk("dropped_pulse", 32'(dropped), 0);
        for (int k = 1; k <= 53; k++) begin
            tick_on(1, 5'b00000);
            chk("regap_52", 32'(dropped), (k == 53) ? 1 : 0);
            quiet(1, 5'b00000);
        end

        // halt and resume
        step(0, 0, 0, 1, 0);
        x0 = obj_x[0 +: X_W]; x1 = obj_x[X_W +: X_W]; x2 = obj_x[2*X_W +: X_W];
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0, 1, 0);
            step(0, 0, 0, 1, 0);
        end
        chk("halt_x0", 32'(obj_x[0 +: X_W]), 32'(x0));
        chk("halt_x2", 32'(obj_x[2*X_W +: X_W]), 32'(x2));
        step(0, 1, 1, 1, 0);
        chk("resume_ignored_tick", 32'(obj_x[X_W +: X_W]), 32'(x1));
        tick_on(1, 0);
        chk("resume_x0", 32'(obj_x[0 +: X_W]), 32'(x0) - 1);
        quiet(1, 0);

        // reset coincident with a tick while running
        step(1, 1, 1, 1, 0);
        chk("reset_valid", 32'(obj_valid), 0);
        chk("reset_x", 32'(obj_x), 0);

        // scroll to x=3, then speed 2 leaves x=1, then retire
        step(0, 0, 1, 7, 0);
        for (int k = 1; k <= 25; k++) begin
            tick_on(7, 0);
            if (k == 25) chk("after_reset_spawn", 32'(spawn), 1);
            quiet(7, 0);
        end
        for (int k = 0; k < 91; k++) begin
            tick_on(7, 0);
            quiet(7, 0);
        end
        chk("scroll_x3", 32'(obj_x[0 +: X_W]), 3);
        tick_on(2, 0);
        chk("scroll_x1", 32'(obj_x[0 +: X_W]), 1);
        chk("scroll_valid", 32'(obj_valid[0]), 1);
        quiet(2, 0);
        tick_on(2, 0);
        chk("retire", 32'(obj_valid[0]), 0);
        quiet(2, 0);
        x1 = obj_x[X_W +: X_W];
        for (int k = 0; k < 10; k++) begin
            tick_on(0, 0);
            quiet(0, 0);
        end
        chk("speed0_x1", 32'(obj_x[X_W +: X_W]), 32'(x1));

        // type map table
        for (int v = 0; v < 4; v++) begin
            step(1, 0, 0, 0, 0);
            step(0, 0, 1, 0, tmap[v].rnd);
            for (int k = 1; k <= 25; k++) begin
                tick_on(0, tmap[v].rnd);
                if (k == 25) begin
                    chk("tmap_spawn", 32'(spawn), 1);
                    chk("tmap_type", 32'(obj_type[1:0]), 32'(tmap[v].exp_type));
                end
                quiet(0, tmap[v].rnd);
            end
        end

        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_leftover: got %0d expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
